airlock_pressure_ctrl: RTL and testbench

Controls the airlock chamber pump through a full evacuate/re-pressurize cycle. Pump run times are parametrised, and the block tracks progress with a down-counter. It enforces door interlocks, handles abort and fault recovery, and drives the door-unlock outputs. It sits between the operator request logic and the door/pump drivers.

---
 rtl/airlock_pkg.sv | 17 +
 rtl/airlock_pressure_ctrl_if.sv | 35 +++
 rtl/airlock_timer.sv | 28 ++
 rtl/airlock_pressure_ctrl.sv | 103 ++++++++++
 tb/tb_airlock_pressure_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/airlock_pkg.sv
// Shared types and defaults for the airlock pressure controller.
// Holds the chamber state encoding and the default pump phase lengths.
package airlock_pkg;

    typedef enum logic [2:0] {
        PRESSURIZED  = 3'd0,
        EVACUATING   = 3'd1,
        EVACUATED    = 3'd2,
        PRESSURIZING = 3'd3,
        FAULT        = 3'd4
    } airlock_state_e;

    localparam int DEF_EVAC_CYCLES  = 8;
    localparam int DEF_PRESS_CYCLES = 6;
    localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/airlock_pressure_ctrl_if.sv
// Request/sensor/status bundle between the operator logic, the door/pump
// drivers and the airlock controller.
//   slave  : the controller (takes requests and sensors, drives status)
//   master : the surrounding logic (drives requests and sensors)
interface airlock_pressure_ctrl_if
    import airlock_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             begin_Evacuation;
    logic             begin_Pressurization;
    logic             Abort;
    logic             InnerClosed;
    logic             OuterClosed;
    logic             Evacuation;
    logic             Pressurization;
    logic             Pressurized;
    logic             Evacuated;
    logic             InnerUnlock;
    logic             OuterUnlock;
    logic             Fault;
    logic [CNT_W-1:0] Remaining;

    modport slave (
        input  begin_Evacuation, begin_Pressurization, Abort, InnerClosed, OuterClosed,
        output Evacuation, Pressurization, Pressurized, Evacuated,
               InnerUnlock, OuterUnlock, Fault, Remaining
    );

    modport master (
        output begin_Evacuation, begin_Pressurization, Abort, InnerClosed, OuterClosed,
        input  Evacuation, Pressurization, Pressurized, Evacuated,
               InnerUnlock, OuterUnlock, Fault, Remaining
    );
endinterface

// File: rtl/airlock_timer.sv
// Loadable down-counter used to time the pump phases.
//   clk, rst  : clock, asynchronous active-high reset (count clears to 0)
//   load      : load load_val this cycle (takes precedence over en)
//   load_val  : value to load
//   en        : decrement by one
//   count     : current value
//   zero      : count == 0
module airlock_timer
    import airlock_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       count <= '0;
        else if (load) count <= load_val;
        else if (en)   count <= count - 1'b1;
    end

    assign zero = (count == '0);
endmodule

// File: rtl/airlock_pressure_ctrl.sv
// Airlock chamber controller: runs the evacuate / re-pressurize cycle,
// enforces the door interlocks, handles abort and fault recovery, and
// drives the door-unlock outputs. Moore machine: outputs decode only from
// the state register and the phase counter.
//   Clock, Reset : clock, asynchronous active-high reset
//   bus          : requests/sensors in, status/unlocks/Remaining out
module airlock_pressure_ctrl
    import airlock_pkg::*;
#(
    parameter int EVAC_CYCLES  = DEF_EVAC_CYCLES,
    parameter int PRESS_CYCLES = DEF_PRESS_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                   Clock,
    input  logic                   Reset,
    airlock_pressure_ctrl_if.slave bus
);
    // Counter holds "cycles left after this one", so loading N-1 gives N pump cycles.
    localparam logic [CNT_W-1:0] EVAC_LOAD  = CNT_W'(EVAC_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);

    airlock_state_e   state, state_n;
    logic             load, en, zero;
    logic [CNT_W-1:0] load_val, count;
    logic             doors_closed, pumping;

    assign doors_closed = bus.InnerClosed & bus.OuterClosed;

    airlock_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (Clock),
        .rst      (Reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .count    (count),
        .zero     (zero)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= PRESSURIZED;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        load_val = '0;
        en       = 1'b0;
        case (state)
            PRESSURIZED: begin
                if (bus.begin_Evacuation && doors_closed) begin
                    state_n  = EVACUATING;
                    load     = 1'b1;
                    load_val = EVAC_LOAD;
                end
            end
            EVACUATING: begin
                if (!doors_closed) begin
                    state_n = FAULT;
                end else if (bus.Abort) begin
                    state_n  = PRESSURIZING;
                    load     = 1'b1;
                    load_val = PRESS_LOAD;
                end else if (zero) begin
                    state_n = EVACUATED;
                end else begin
                    en = 1'b1;
                end
            end
            EVACUATED: begin
                if ((bus.begin_Pressurization || bus.Abort) && doors_closed) begin
                    state_n  = PRESSURIZING;
                    load     = 1'b1;
                    load_val = PRESS_LOAD;
                end
            end
            PRESSURIZING: begin
                if (!doors_closed)  state_n = FAULT;
                else if (zero)      state_n = PRESSURIZED;
                else                en      = 1'b1;
            end
            FAULT: begin
                if (bus.begin_Pressurization && doors_closed) begin
                    state_n  = PRESSURIZING;
                    load     = 1'b1;
                    load_val = PRESS_LOAD;
                end
            end
            default: state_n = PRESSURIZED;
        endcase
    end

    // Counter contents are stale outside the pump states, so mask them.
    assign pumping            = (state == EVACUATING) || (state == PRESSURIZING);
    assign bus.Evacuation     = (state == EVACUATING);
    assign bus.Pressurization = (state == PRESSURIZING);
    assign bus.Pressurized    = (state == PRESSURIZED);
    assign bus.Evacuated      = (state == EVACUATED);
    assign bus.InnerUnlock    = (state == PRESSURIZED);
    assign bus.OuterUnlock    = (state == EVACUATED);
    assign bus.Fault          = (state == FAULT);
    assign bus.Remaining      = pumping ? count : '0;
endmodule

// File: tb/tb_airlock_pressure_ctrl.sv
module tb_airlock_pressure_ctrl;
    localparam int EVAC  = 4;
    localparam int PRESS = 3;
    localparam int CW    = 8;

    logic Clock, Reset;
    int   n_checks = 0;
    int   n_fails  = 0;
    bit   run_cmp  = 0;

    airlock_pressure_ctrl_if #(.CNT_W(CW)) bus ();

    airlock_pressure_ctrl #(
        .EVAC_CYCLES (EVAC),
        .PRESS_CYCLES(PRESS),
        .CNT_W       (CW)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Chamber condition plus the number of pump cycles still to run
    // (including the current one); Remaining is therefore left-1.
    typedef enum int { AT_PRESSURE, PUMPING_OUT, AT_VACUUM, FILLING, LOCKED_OUT } phase_t;
    phase_t m_phase = AT_PRESSURE;
    int     m_left  = 0;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_phase <= AT_PRESSURE;
            m_left  <= 0;
        end else begin
            case (m_phase)
                AT_PRESSURE:
                    if (bus.begin_Evacuation && bus.InnerClosed && bus.OuterClosed) begin
                        m_phase <= PUMPING_OUT; m_left <= EVAC;
                    end
                PUMPING_OUT:
                    if (!(bus.InnerClosed && bus.OuterClosed)) m_phase <= LOCKED_OUT;
                    else if (bus.Abort) begin m_phase <= FILLING; m_left <= PRESS; end
                    else if (m_left == 1) m_phase <= AT_VACUUM;
                    else m_left <= m_left - 1;
                AT_VACUUM:
                    if ((bus.begin_Pressurization || bus.Abort) && bus.InnerClosed && bus.OuterClosed) begin
                        m_phase <= FILLING; m_left <= PRESS;
                    end
                FILLING:
                    if (!(bus.InnerClosed && bus.OuterClosed)) m_phase <= LOCKED_OUT;
                    else if (m_left == 1) m_phase <= AT_PRESSURE;
                    else m_left <= m_left - 1;
                LOCKED_OUT:
                    if (bus.begin_Pressurization && bus.InnerClosed && bus.OuterClosed) begin
                        m_phase <= FILLING; m_left <= PRESS;
                    end
                default: m_phase <= AT_PRESSURE;
            endcase
        end
    end

    // Every cycle: DUT outputs against the model, plus the unlock invariants.
    always @(negedge Clock) begin
        if (run_cmp) begin
            chk("evacuation",     int'(bus.Evacuation),     int'(m_phase == PUMPING_OUT));
            chk("pressurization", int'(bus.Pressurization), int'(m_phase == FILLING));
            chk("pressurized",    int'(bus.Pressurized),    int'(m_phase == AT_PRESSURE));
            chk("evacuated",      int'(bus.Evacuated),      int'(m_phase == AT_VACUUM));
            chk("inner_unlock",   int'(bus.InnerUnlock),    int'(m_phase == AT_PRESSURE));
            chk("outer_unlock",   int'(bus.OuterUnlock),    int'(m_phase == AT_VACUUM));
            chk("fault",          int'(bus.Fault),          int'(m_phase == LOCKED_OUT));
            chk("remaining",      int'(bus.Remaining),
                (m_phase == PUMPING_OUT || m_phase == FILLING) ? m_left - 1 : 0);
            chk("one_unlock",     int'(bus.InnerUnlock && bus.OuterUnlock), 0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    task automatic chk_idle_pressurized(input string tag);
        chk({tag, "_pressurized"}, int'(bus.Pressurized), 1);
        chk({tag, "_inner_unlock"}, int'(bus.InnerUnlock), 1);
        chk({tag, "_others"}, int'({bus.Evacuation, bus.Pressurization, bus.Evacuated,
                                    bus.OuterUnlock, bus.Fault}), 0);
        chk({tag, "_remaining"}, int'(bus.Remaining), 0);
    endtask

    initial begin
        Reset                    = 1'b1;
        bus.begin_Evacuation     = 1'b0;
        bus.begin_Pressurization = 1'b0;
        bus.Abort                = 1'b0;
        bus.InnerClosed          = 1'b1;
        bus.OuterClosed          = 1'b1;
        #12;
        chk_idle_pressurized("reset");
        Reset   = 1'b0;
        run_cmp = 1'b1;

        // Full evacuation: 4 pump cycles counting 3,2,1,0.
        bus.begin_Evacuation = 1'b1; step(); bus.begin_Evacuation = 1'b0;
        for (int r = EVAC - 1; r >= 0; r--) begin
            chk("evac_run", int'(bus.Evacuation), 1);
            chk("evac_rem", int'(bus.Remaining), r);
            step();
        end
        chk("evacuated", int'(bus.Evacuated), 1);
        chk("evacd_outer", int'(bus.OuterUnlock), 1);
        chk("evacd_inner", int'(bus.InnerUnlock), 0);

        // begin_Evacuation ignored at vacuum.
        bus.begin_Evacuation = 1'b1; step(); bus.begin_Evacuation = 1'b0;
        chk("evacd_hold", int'(bus.Evacuated), 1);

        // Re-pressurize: 3 cycles counting 2,1,0.
        bus.begin_Pressurization = 1'b1; step(); bus.begin_Pressurization = 1'b0;
        for (int r = PRESS - 1; r >= 0; r--) begin
            chk("press_run", int'(bus.Pressurization), 1);
            chk("press_rem", int'(bus.Remaining), r);
            step();
        end
        chk_idle_pressurized("repress");

        // Abort in the 2nd evacuation cycle.
        bus.begin_Evacuation = 1'b1; step(); bus.begin_Evacuation = 1'b0;
        step();
        chk("abort_pre_rem", int'(bus.Remaining), EVAC - 2);
        bus.Abort = 1'b1; step(); bus.Abort = 1'b0;
        chk("abort_press", int'(bus.Pressurization), 1);
        chk("abort_evac", int'(bus.Evacuation), 0);
        chk("abort_rem", int'(bus.Remaining), PRESS - 1);
        // Abort is ignored while filling.
        bus.Abort = 1'b1; step(); bus.Abort = 1'b0;
        chk("abort_ign_rem", int'(bus.Remaining), PRESS - 2);
        repeat (2) step();
        chk("abort_done", int'(bus.Pressurized), 1);

        // Outer door opens mid-evacuation -> fault, then recovery.
        bus.begin_Evacuation = 1'b1; step(); bus.begin_Evacuation = 1'b0;
        bus.OuterClosed = 1'b0; step();
        chk("fault_flag", int'(bus.Fault), 1);
        chk("fault_outs", int'({bus.Evacuation, bus.Pressurization, bus.Pressurized,
                                bus.Evacuated, bus.InnerUnlock, bus.OuterUnlock}), 0);
        chk("fault_rem", int'(bus.Remaining), 0);
        // Recovery needs closed doors.
        bus.begin_Pressurization = 1'b1; step();
        chk("fault_hold", int'(bus.Fault), 1);
        bus.OuterClosed = 1'b1; step(); bus.begin_Pressurization = 1'b0;
        chk("recover_rem", int'(bus.Remaining), PRESS - 1);
        repeat (PRESS) step();
        chk("recover_done", int'(bus.Pressurized), 1);

        // Request with the inner door open is ignored.
        bus.InnerClosed = 1'b0; bus.begin_Evacuation = 1'b1; step();
        bus.begin_Evacuation = 1'b0; bus.InnerClosed = 1'b1;
        chk("door_open_ign", int'(bus.Pressurized), 1);
        chk("door_open_evac", int'(bus.Evacuation), 0);

        // Both requests at pressure: evacuation wins; at vacuum: pressurization wins.
        bus.begin_Evacuation = 1'b1; bus.begin_Pressurization = 1'b1; step();
        bus.begin_Pressurization = 1'b0; bus.begin_Evacuation = 1'b0;
        chk("both_at_press", int'(bus.Evacuation), 1);
        repeat (EVAC) step();
        bus.begin_Evacuation = 1'b1; bus.begin_Pressurization = 1'b1; step();
        bus.begin_Pressurization = 1'b0; bus.begin_Evacuation = 1'b0;
        chk("both_at_vac", int'(bus.Pressurization), 1);
        // Door opens while filling -> fault; recover.
        bus.InnerClosed = 1'b0; step(); bus.InnerClosed = 1'b1;
        chk("fill_fault", int'(bus.Fault), 1);
        bus.begin_Pressurization = 1'b1; step(); bus.begin_Pressurization = 1'b0;
        step();

        // Asynchronous reset between edges while filling.
        chk("pre_reset_fill", int'(bus.Pressurization), 1);
        #1 Reset = 1'b1;
        #1 chk_idle_pressurized("async_reset");
        step();
        Reset = 1'b0;

        // Abort from vacuum also re-pressurizes.
        bus.begin_Evacuation = 1'b1; step(); bus.begin_Evacuation = 1'b0;
        repeat (EVAC) step();
        bus.Abort = 1'b1; step(); bus.Abort = 1'b0;
        chk("vac_abort", int'(bus.Pressurization), 1);
        repeat (PRESS + 2) step();

        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
